noc_rr_arb_node: RTL and testbench
==================================

// Module: noc_rr_arb_node
// PURPOSE
// Generalised N-input NoC switch node: RADIX core-side request ports merge onto one memory-side port.
// - Per-port input FIFOs, round-robin arbitration, registered output.
// - Port index pushed into a route tag; memory responses are steered back by popping that tag.
// - Nodes cascade NETWORK_DEPTH levels deep between cores and a single memory.
// PARAMETERS
// DATA_WIDTH     512  request/response payload bits
// ADDR_WIDTH     32   request address bits
// RADIX          4    number of core-side ports; power of two, >=2
// NETWORK_DEPTH  2    levels of nodes in the tree
// FIFO_DEPTH     4    entries per input FIFO; power of two, >=2
// SEL_W (local)  $clog2(RADIX);  TAG_W (local) SEL_W*NETWORK_DEPTH
// PORTS
// clk            in   1                  clock, all state on posedge
// rst            in   1                  async reset, active-high
// req_valid_in   in   [RADIX]            per-port request valid
// req_ready_out  out  [RADIX]            per-port request ready
// req_data_in    in   [RADIX][DATA_WIDTH] per-port write data
// req_addr_in    in   [RADIX][ADDR_WIDTH] per-port address
// req_tag_in     in   [RADIX][TAG_W]     per-port route tag from upstream
// req_valid_out  out  1                  merged request valid
// req_ready_in   in   1                  downstream ready
// req_data_out   out  DATA_WIDTH         merged data
// req_addr_out   out  ADDR_WIDTH         merged address
// req_tag_out    out  TAG_W              tag with granted port pushed in
// rsp_valid_in   in   1                  response valid from memory side
// rsp_ready_out  out  1                  response ready to memory side
// rsp_data_in    in   DATA_WIDTH         response data
// rsp_tag_in     in   TAG_W              response route tag
// rsp_valid_out  out  [RADIX]            one-hot response valid per port
// rsp_ready_in   in   [RADIX]            per-port response ready
// rsp_data_out   out  DATA_WIDTH         response data, shared by all ports
// rsp_tag_out    out  TAG_W              tag with this level popped
// BEHAVIOUR
// - Reset (async, rst=1): FIFOs empty, output/response regs invalid.
//   - rr pointer=0; req_valid_out=0, rsp_valid_out=0, rsp_ready_out=0, req_ready_out=0 while rst=1.
//   - Data/tag outputs reset to 0.
// - Handshake: transfer on valid&&ready at posedge.
//   - A valid is never dropped, and its payload holds stable, until accepted.
// - req_ready_out[p] = !rst && !full[p].
//   - A full FIFO does not accept even if popped the same cycle (no pass-through).
// - Output reg loads when (!req_valid_out || req_ready_in) and any FIFO is non-empty.
//   - Load is a pop of the granted FIFO head.
// - Round-robin arbitration:
//   - Search starts at rr pointer, wraps RADIX-1 -> 0; first non-empty FIFO is granted.
//   - On grant g, pointer <= (g+1) mod RADIX; no grant leaves the pointer unchanged.
// - Latency: request accepted in cycle c (empty FIFO, idle output) gives req_valid_out=1 in cycle c+2.
//   - Throughput is 1 request/cycle when req_ready_in=1.
// - Tag push: req_tag_out = {req_tag_in[g][TAG_W-SEL_W-1:0], SEL_W'(g)}; top SEL_W bits are discarded.
// - FIFO pointers wrap mod FIFO_DEPTH; a separate count distinguishes full from empty.
//   - Simultaneous push+pop on a non-full FIFO keeps the count.
// - Response path: one-entry register.
//   - rsp_ready_out = !rst && (!rsp_vld || rsp_ready_in[rsp_port]).
//   - On accept: rsp_port <= rsp_tag_in[SEL_W-1:0]; rsp_tag_out <= {SEL_W'0, rsp_tag_in[TAG_W-1:SEL_W]}.
//   - rsp_valid_out[p] = rsp_vld && (rsp_port==p); latency 1 cycle; back-to-back when the target port is ready.
// - Request and response paths are independent; simultaneous activity is allowed.
// - Reset mid-operation: all in-flight requests and responses are discarded; no stale valid after rst deasserts.
// CONFIGURATION
// - NOC_STALL_CNT_EN defined:
//   - Adds output stall_cnt [31:0]; increments each cycle req_valid_out && !req_ready_in.
//   - Saturates at 32'hFFFF_FFFF; reset to 0.
// - NOC_STALL_CNT_EN undefined: port and counter logic are absent; all other behaviour is identical.
// TESTING (RADIX=4, NETWORK_DEPTH=2, FIFO_DEPTH=4, TAG_W=4)
// 1. Port2 sends addr 32'h100, tag 4'b0001, req_ready_in=1, accepted in cycle c
//    -> req_valid_out=1 in cycle c+2, addr 32'h100, tag_out 4'b0110, one cycle only.
// 2. All 4 ports valid continuously, req_ready_in=1 -> grant order 0,1,2,3,0,1...
//    - One per cycle; each port gets 25% of grants.
// 3. req_ready_in=0, port0 streams -> 5 requests accepted (4 FIFO + 1 output reg), then req_ready_out[0]=0.
//    - req_*_out stable; after ready returns, all 5 emerge in order.
// 4. rsp_tag_in 4'b1011, rsp_ready_in=4'b0000 -> rsp_valid_out=4'b1000, rsp_tag_out 4'b0010.
//    - rsp_ready_out=0 until rsp_ready_in[3]=1, then one-cycle accept.
// 5. rst pulsed mid-cycle with 3 queued requests and a pending response
//    -> all valids 0 immediately; after release, req_ready_out=4'b1111.
//    - No output until new input arrives; first grant goes to port0.
// 6. With NOC_STALL_CNT_EN: hold req_valid_out with req_ready_in=0 for 10 cycles -> stall_cnt=10.
//    - Preload near max -> stall_cnt sticks at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/noc_rr_arb_node.sv
// noc_rr_arb_node: RADIX-to-1 NoC switch node.
// Each core-side port has its own FIFO. A round-robin arbiter drains the FIFOs
// into one registered memory-side request port, and pushes the granted port
// index into the route tag. Responses come back through a one-entry register.
// The response tag's low SEL_W bits select the target port, and the tag is
// shifted right by one level on the way out.
// Optional feature: define NOC_STALL_CNT_EN to add a saturating stall_cnt output.
module noc_rr_arb_node #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 32,
    parameter int RADIX         = 4,
    parameter int NETWORK_DEPTH = 2,
    parameter int FIFO_DEPTH    = 4,
    localparam int SEL_W        = $clog2(RADIX),
    localparam int TAG_W        = SEL_W * NETWORK_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [RADIX-1:0]                  req_valid_in,
    output logic [RADIX-1:0]                  req_ready_out,
    input  logic [RADIX-1:0][DATA_WIDTH-1:0]  req_data_in,
    input  logic [RADIX-1:0][ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [RADIX-1:0][TAG_W-1:0]       req_tag_in,
    output logic                              req_valid_out,
    input  logic                              req_ready_in,
    output logic [DATA_WIDTH-1:0]             req_data_out,
    output logic [ADDR_WIDTH-1:0]             req_addr_out,
    output logic [TAG_W-1:0]                  req_tag_out,
    input  logic                              rsp_valid_in,
    output logic                              rsp_ready_out,
    input  logic [DATA_WIDTH-1:0]             rsp_data_in,
    input  logic [TAG_W-1:0]                  rsp_tag_in,
    output logic [RADIX-1:0]                  rsp_valid_out,
    input  logic [RADIX-1:0]                  rsp_ready_in,
    output logic [DATA_WIDTH-1:0]             rsp_data_out,
    output logic [TAG_W-1:0]                  rsp_tag_out
`ifdef NOC_STALL_CNT_EN
    ,
    output logic [31:0]                       stall_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + TAG_W;

    logic [RADIX-1:0]              fifo_empty;
    logic [RADIX-1:0]              fifo_full;
    logic [RADIX-1:0]              fifo_push;
    logic [RADIX-1:0]              fifo_pop;
    logic [RADIX-1:0][ENTRY_W-1:0] fifo_head;

    logic [SEL_W-1:0]              rr_ptr_reg;
    logic [SEL_W-1:0]              arb_cand;
    logic [SEL_W-1:0]              grant_idx;
    logic                          grant_found;
    logic                          out_load;
    logic [ENTRY_W-1:0]            grant_entry;
    logic [TAG_W+SEL_W-1:0]        tag_push_wide;

    logic                          rsp_vld_reg;
    logic [SEL_W-1:0]              rsp_port_reg;
    logic                          rsp_accept;
    logic [TAG_W+SEL_W-1:0]        rsp_tag_wide;

    // Per-port FIFOs. The head is read combinationally so a request pushed in
    // cycle c can be arbitrated in c+1 and appear on the output in c+2.
    genvar gi;
    generate
        for (gi = 0; gi < RADIX; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
            logic [PTR_W-1:0]   wr_ptr_reg;
            logic [PTR_W-1:0]   rd_ptr_reg;
            logic [CNT_W-1:0]   cnt_reg;

            assign fifo_empty[gi]    = (cnt_reg == '0);
            assign fifo_full[gi]     = (cnt_reg == CNT_W'(FIFO_DEPTH));
            // A full FIFO never accepts, even when it is being popped this cycle.
            assign req_ready_out[gi] = !rst && !fifo_full[gi];
            assign fifo_push[gi]     = req_valid_in[gi] && req_ready_out[gi];
            assign fifo_pop[gi]      = out_load && (grant_idx == SEL_W'(gi));
            assign fifo_head[gi]     = mem_reg[rd_ptr_reg];

            // Storage array carries no reset; occupancy is tracked by cnt_reg.
            always_ff @(posedge clk) begin
                if (fifo_push[gi]) begin
                    mem_reg[wr_ptr_reg] <= {req_data_in[gi], req_addr_in[gi], req_tag_in[gi]};
                end
            end

            // Pointers wrap naturally; the count separates full from empty.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (fifo_push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (fifo_pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (fifo_push[gi] && !fifo_pop[gi])      cnt_reg <= cnt_reg + 1'b1;
                    else if (fifo_pop[gi] && !fifo_push[gi]) cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    endgenerate

    // Round-robin search: first non-empty FIFO starting at the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        arb_cand    = '0;
        for (int i = 0; i < RADIX; i++) begin
            arb_cand = rr_ptr_reg + SEL_W'(i);
            if (!grant_found && !fifo_empty[arb_cand]) begin
                grant_found = 1'b1;
                grant_idx   = arb_cand;
            end
        end
    end

    assign out_load      = grant_found && (!req_valid_out || req_ready_in);
    assign grant_entry   = fifo_head[grant_idx];
    // Shift the granted index into the low bits; the oldest level falls off the top.
    assign tag_push_wide = {grant_entry[TAG_W-1:0], grant_idx};

    // Registered output stage and arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_out <= 1'b0;
            req_data_out  <= '0;
            req_addr_out  <= '0;
            req_tag_out   <= '0;
            rr_ptr_reg    <= '0;
        end else if (out_load) begin
            req_valid_out <= 1'b1;
            req_data_out  <= grant_entry[ENTRY_W-1 -: DATA_WIDTH];
            req_addr_out  <= grant_entry[TAG_W +: ADDR_WIDTH];
            req_tag_out   <= tag_push_wide[TAG_W-1:0];
            rr_ptr_reg    <= grant_idx + 1'b1;
        end else if (req_ready_in) begin
            req_valid_out <= 1'b0;
        end
    end

    assign rsp_ready_out = !rst && (!rsp_vld_reg || rsp_ready_in[rsp_port_reg]);
    assign rsp_accept    = rsp_valid_in && rsp_ready_out;
    // Pop this level: drop the low SEL_W bits and zero-fill from the top.
    assign rsp_tag_wide  = {{SEL_W{1'b0}}, rsp_tag_in} >> SEL_W;

    // One-entry response register steered by the low tag bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_reg  <= 1'b0;
            rsp_port_reg <= '0;
            rsp_data_out <= '0;
            rsp_tag_out  <= '0;
        end else if (rsp_accept) begin
            rsp_vld_reg  <= 1'b1;
            rsp_port_reg <= rsp_tag_in[SEL_W-1:0];
            rsp_data_out <= rsp_data_in;
            rsp_tag_out  <= rsp_tag_wide[TAG_W-1:0];
        end else if (rsp_vld_reg && rsp_ready_in[rsp_port_reg]) begin
            rsp_vld_reg  <= 1'b0;
        end
    end

    generate
        for (gi = 0; gi < RADIX; gi++) begin : g_rsp_vld
            assign rsp_valid_out[gi] = rsp_vld_reg && (rsp_port_reg == SEL_W'(gi));
        end
    endgenerate

`ifdef NOC_STALL_CNT_EN
    // Count cycles the output is held by downstream backpressure; saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (req_valid_out && !req_ready_in && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_rr_arb_node.sv
// Self-checking bench for noc_rr_arb_node (RADIX=4, NETWORK_DEPTH=2, FIFO_DEPTH=4).
// Table-driven request/response vectors plus directed multi-cycle sequences.
module tb_noc_rr_arb_node;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int R  = 4;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [R-1:0]          req_valid_in;
    logic [R-1:0]          req_ready_out;
    logic [R-1:0][DW-1:0]  req_data_in;
    logic [R-1:0][AW-1:0]  req_addr_in;
    logic [R-1:0][TW-1:0]  req_tag_in;
    logic                  req_valid_out;
    logic                  req_ready_in;
    logic [DW-1:0]         req_data_out;
    logic [AW-1:0]         req_addr_out;
    logic [TW-1:0]         req_tag_out;
    logic                  rsp_valid_in;
    logic                  rsp_ready_out;
    logic [DW-1:0]         rsp_data_in;
    logic [TW-1:0]         rsp_tag_in;
    logic [R-1:0]          rsp_valid_out;
    logic [R-1:0]          rsp_ready_in;
    logic [DW-1:0]         rsp_data_out;
    logic [TW-1:0]         rsp_tag_out;
`ifdef NOC_STALL_CNT_EN
    logic [31:0]           stall_cnt;
`endif

    noc_rr_arb_node #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RADIX(R), .NETWORK_DEPTH(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_data_in(req_data_in), .req_addr_in(req_addr_in), .req_tag_in(req_tag_in),
        .req_valid_out(req_valid_out), .req_ready_in(req_ready_in),
        .req_data_out(req_data_out), .req_addr_out(req_addr_out), .req_tag_out(req_tag_out),
        .rsp_valid_in(rsp_valid_in), .rsp_ready_out(rsp_ready_out),
        .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out)
`ifdef NOC_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int         port;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [3:0]  exp_tag;
    } req_vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] data;
        logic [3:0]  exp_vld;
        logic [3:0]  exp_tag;
    } rsp_vec_t;

    req_vec_t rv[4];
    rsp_vec_t sv[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_in = '0;
        req_data_in  = '0;
        req_addr_in  = '0;
        req_tag_in   = '0;
        req_ready_in = 1'b0;
        rsp_valid_in = 1'b0;
        rsp_data_in  = '0;
        rsp_tag_in   = '0;
        rsp_ready_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    int accepted;
    logic will_accept;
    int grants[R];

    initial begin
        rv[0] = '{2, 32'h100, 32'hA0, 4'b0001, 4'b0110};
        rv[1] = '{0, 32'h200, 32'hA1, 4'b0011, 4'b1100};
        rv[2] = '{3, 32'h300, 32'hA2, 4'b1110, 4'b1011};
        rv[3] = '{1, 32'h400, 32'hA3, 4'b0101, 4'b0101};

        sv[0] = '{4'b1011, 32'hD0, 4'b1000, 4'b0010};
        sv[1] = '{4'b0100, 32'hD1, 4'b0001, 4'b0001};
        sv[2] = '{4'b1110, 32'hD2, 4'b0100, 4'b0011};
        sv[3] = '{4'b0001, 32'hD3, 4'b0010, 4'b0000};

        // Reset state
        rst = 1'b1;
        clear_inputs();
        tick();
        check("rst_req_valid_out", req_valid_out, 0);
        check("rst_rsp_valid_out", rsp_valid_out, 0);
        check("rst_req_ready_out", req_ready_out, 0);
        check("rst_rsp_ready_out", rsp_ready_out, 0);
        check("rst_req_tag_out", req_tag_out, 0);
        check("rst_req_data_out", req_data_out, 0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready_out, 4'b1111);
        check("post_rst_rsp_ready", rsp_ready_out, 1);
        tick();

        // Single requests: latency c+2, one cycle valid, tag push
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            req_ready_in               = 1'b1;
            req_valid_in[rv[i].port]   = 1'b1;
            req_addr_in[rv[i].port]    = rv[i].addr;
            req_data_in[rv[i].port]    = rv[i].data;
            req_tag_in[rv[i].port]     = rv[i].tag;
            tick();
            req_valid_in = '0;
            check("req_lat_c1_valid", req_valid_out, 0);
            tick();
            check("req_lat_c2_valid", req_valid_out, 1);
            check("req_addr", req_addr_out, rv[i].addr);
            check("req_data", req_data_out, rv[i].data);
            check("req_tag_push", req_tag_out, rv[i].exp_tag);
            $display("[TB] req port %0d addr %0h tag_in %b -> tag_out %b", rv[i].port, rv[i].addr, rv[i].tag, req_tag_out);
            tick();
            check("req_one_cycle", req_valid_out, 0);
        end

        // All ports streaming: grant order 0,1,2,3,0,...
        clear_inputs();
        do_reset();
        for (int p = 0; p < R; p++) begin
            grants[p]      = 0;
            req_addr_in[p] = 32'h1000 + p;
        end
        req_valid_in = 4'b1111;
        req_ready_in = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("rr_valid", req_valid_out, 1);
            check("rr_addr", req_addr_out, 32'h1000 + (i % 4));
            check("rr_tag", req_tag_out, i % 4);
            grants[req_tag_out[1:0]]++;
            $display("[TB] rr grant %0d -> port %0d", i, req_tag_out[1:0]);
            tick();
        end
        for (int p = 0; p < R; p++) check("rr_share", grants[p], 2);

        // Backpressure: five requests absorbed, then port0 stalls
        clear_inputs();
        do_reset();
        accepted        = 0;
        req_valid_in[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr_in[0] = 32'h3000 + accepted;
            will_accept    = req_ready_out[0];
            tick();
            if (will_accept) accepted++;
        end
        check("bp_accepted", accepted, 5);
        check("bp_ready0_low", req_ready_out[0], 0);
        check("bp_hold_valid", req_valid_out, 1);
        check("bp_hold_addr", req_addr_out, 32'h3000);
        tick();
        check("bp_hold_addr2", req_addr_out, 32'h3000);
        req_valid_in = '0;
        req_ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_drain_valid", req_valid_out, 1);
            check("bp_drain_addr", req_addr_out, 32'h3000 + k);
            $display("[TB] drain %0d addr %0h", k, req_addr_out);
            tick();
        end
        check("bp_drain_done", req_valid_out, 0);

        // Response held until target port ready
        clear_inputs();
        do_reset();
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 4'b1011;
        rsp_data_in  = 32'hBEEF;
        tick();
        check("rsp_onehot", rsp_valid_out, 4'b1000);
        check("rsp_tag_pop", rsp_tag_out, 4'b0010);
        check("rsp_data", rsp_data_out, 32'hBEEF);
        rsp_tag_in  = 4'b0001;
        rsp_data_in = 32'hCAFE;
        #1;
        check("rsp_blocked", rsp_ready_out, 0);
        tick();
        check("rsp_still_held", rsp_valid_out, 4'b1000);
        rsp_ready_in = 4'b1000;
        #1;
        check("rsp_ready_when_p3", rsp_ready_out, 1);
        tick();
        rsp_valid_in = 1'b0;
        check("rsp_second_onehot", rsp_valid_out, 4'b0010);
        check("rsp_second_tag", rsp_tag_out, 4'b0000);
        tick();
        check("rsp_second_held", rsp_valid_out, 4'b0010);
        rsp_ready_in = 4'b1111;
        tick();
        check("rsp_drained", rsp_valid_out, 0);

        // Response table, back-to-back
        rsp_ready_in = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            rsp_valid_in = 1'b1;
            rsp_tag_in   = sv[i].tag;
            rsp_data_in  = sv[i].data;
            #1;
            check("rsp_tbl_ready", rsp_ready_out, 1);
            tick();
            check("rsp_tbl_vld", rsp_valid_out, sv[i].exp_vld);
            check("rsp_tbl_tag", rsp_tag_out, sv[i].exp_tag);
            check("rsp_tbl_data", rsp_data_out, sv[i].data);
            $display("[TB] rsp tag_in %b -> vld %b tag_out %b", sv[i].tag, rsp_valid_out, rsp_tag_out);
        end
        rsp_valid_in = 1'b0;
        tick();
        check("rsp_tbl_idle", rsp_valid_out, 0);

        // Reset mid-operation
        clear_inputs();
        do_reset();
        req_valid_in   = 4'b0111;
        req_addr_in[0] = 32'h50;
        req_addr_in[1] = 32'h51;
        req_addr_in[2] = 32'h52;
        tick();
        req_valid_in = '0;
        rsp_valid_in = 1'b1;
        rsp_tag_in   = 4'b0010;
        tick();
        rsp_valid_in = 1'b0;
        check("mid_pre_req_valid", req_valid_out, 1);
        check("mid_pre_rsp_valid", rsp_valid_out, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid", req_valid_out, 0);
        check("mid_rst_rsp_valid", rsp_valid_out, 0);
        check("mid_rst_req_ready", req_ready_out, 0);
        check("mid_rst_addr", req_addr_out, 0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        check("mid_post_ready", req_ready_out, 4'b1111);
        check("mid_post_valid", req_valid_out, 0);
        check("mid_post_rsp", rsp_valid_out, 0);
        tick();
        check("mid_post_valid2", req_valid_out, 0);
        req_ready_in   = 1'b1;
        req_valid_in   = 4'b0011;
        req_addr_in[0] = 32'h60;
        req_addr_in[1] = 32'h61;
        tick();
        req_valid_in = '0;
        tick();
        check("mid_first_grant", req_tag_out, 0);
        check("mid_first_addr", req_addr_out, 32'h60);
        tick();
        check("mid_second_grant", req_tag_out, 1);

`ifdef NOC_STALL_CNT_EN
        // Stall counter under sustained backpressure
        clear_inputs();
        do_reset();
        req_valid_in[0] = 1'b1;
        tick();
        req_valid_in = '0;
        tick();
        check("stall_valid", req_valid_out, 1);
        check("stall_start", stall_cnt, 0);
        repeat (10) tick();
        check("stall_10", stall_cnt, 10);
        req_ready_in = 1'b1;
        tick();
        check("stall_hold", stall_cnt, 10);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
